bc_param_top: RTL

BC_PARAM_TOP -- requirements
Module: bc_param_top

---
 rtl/bc_pkg.sv | 11 +
 rtl/bc_fifo.sv | 75 +++++++
 rtl/bc_param_top.sv | 101 ++++++++++
 3 files changed

// File: rtl/bc_pkg.sv
// Shared definitions for the broadcast data path: output-select encodings.
package bc_pkg;

    typedef logic [1:0] bc_sel_t;

    localparam bc_sel_t BC_SEL_DM   = 2'b00;
    localparam bc_sel_t BC_SEL_DRR  = 2'b01;
    localparam bc_sel_t BC_SEL_IMM  = 2'b10;
    localparam bc_sel_t BC_SEL_ZERO = 2'b11;

endpackage

// File: rtl/bc_fifo.sv
// Data-register queue: storage, read/write pointers, occupancy and sticky overflow.
module bc_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_vld_i,
    input  logic [DW-1:0] push_dt_i,
    input  logic          pop_i,
    input  logic          ovf_clr_i,
    output logic          rdy_o,
    output logic [DW-1:0] head_o,
    output logic [CW-1:0] cnt_o,
    output logic          ovf_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          full;
    logic          push;
    logic          pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign rdy_o = !full;
    assign push  = push_vld_i && !full;
    assign pop   = pop_i && (cnt_q != '0);

    // DEPTH is a power of two, so pointer increment wraps DEPTH-1 -> 0 on its own.
    always_comb begin
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
        cnt_d  = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (pop && !push)
            cnt_d = cnt_q - CW'(1);
        // Overflow wins over a same-cycle clear.
        if (push_vld_i && full)
            ovf_d = 1'b1;
        else if (ovf_clr_i)
            ovf_d = 1'b0;
        else
            ovf_d = ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= push_dt_i;
    end

    assign head_o = (cnt_q != '0) ? mem_q[rptr_q] : '0;
    assign cnt_o  = cnt_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/bc_param_top.sv
// Broadcast bus source: selects memory, queued data-register, immediate or zero data.
// Optional macro BC_BYPASS_EN: push into an empty queue is forwarded to bc_dt in the same cycle.
module bc_param_top
    import bc_pkg::*;
#(
    parameter int DW    = 16,
    parameter int NSRC  = 4,
    parameter int DEPTH = 4,
    localparam int SW   = $clog2(NSRC),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSRC*DW-1:0] drr_src,
    input  logic [SW-1:0]     drr_sclt,
    input  logic              drr_vld,
    output logic              drr_rdy,
    input  logic [1:0]        di_sclt,
    input  logic [DW-1:0]     dm_bc_dt,
    input  logic [DW-1:0]     ps_bc_immdt,
    input  logic              bc_rdy,
    output logic [DW-1:0]     bc_dt,
    output logic              bc_vld,
    output logic [CW-1:0]     bc_cnt,
    input  logic              ovf_clr,
    output logic              bc_ovf
);

    logic [DW-1:0] src_word;
    logic [DW-1:0] head;
    logic          q_empty;
    logic          pop_req;
    logic          fifo_push;
    logic          byp_hit;

    // Out-of-range selects push a zero word.
    always_comb begin
        src_word = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (drr_sclt == SW'(k))
                src_word = drr_src[k*DW +: DW];
        end
    end

    assign q_empty = (bc_cnt == '0);
    assign pop_req = (di_sclt == BC_SEL_DRR) && bc_rdy;

`ifdef BC_BYPASS_EN
    // A bypassed word taken by the consumer never enters the queue.
    assign byp_hit   = q_empty && drr_vld && (di_sclt == BC_SEL_DRR);
    assign fifo_push = drr_vld && !(byp_hit && bc_rdy);
`else
    assign byp_hit   = 1'b0;
    assign fifo_push = drr_vld;
`endif

    bc_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_vld_i (fifo_push),
        .push_dt_i  (src_word),
        .pop_i      (pop_req),
        .ovf_clr_i  (ovf_clr),
        .rdy_o      (drr_rdy),
        .head_o     (head),
        .cnt_o      (bc_cnt),
        .ovf_o      (bc_ovf)
    );

    always_comb begin
        bc_dt  = '0;
        bc_vld = 1'b0;
        case (di_sclt)
            BC_SEL_DM: begin
                bc_dt  = dm_bc_dt;
                bc_vld = 1'b1;
            end
            BC_SEL_DRR: begin
                if (byp_hit) begin
                    bc_dt  = src_word;
                    bc_vld = 1'b1;
                end else begin
                    bc_dt  = head;
                    bc_vld = !q_empty;
                end
            end
            BC_SEL_IMM: begin
                bc_dt  = ps_bc_immdt;
                bc_vld = 1'b1;
            end
            default: begin
                bc_dt  = '0;
                bc_vld = 1'b0;
            end
        endcase
    end

endmodule
